// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU pin bus. It serves two-cell reads,
// sequences write-address/commit bursts, and on halt streams the whole
// cell image out of the dump port.
module mem_bus_responder #(
    parameter int ADDR_W = 10,
    parameter int CELL_W = 6,
    parameter int DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_write,
    input  logic                  write_commit,
    input  logic [ADDR_W-1:0]     addr_data,
    output logic [2*CELL_W-1:0]   mem_result,
    output logic                  halted,
    output logic                  dump_valid,
    output logic [ADDR_W-1:0]     dump_addr,
    output logic [CELL_W-1:0]     dump_data,
    output logic                  dump_done
);

    typedef enum logic [1:0] {
        RUN,
        DUMP,
        DONE
    } state_t;

    localparam logic [1:0] CMD_SETADDR = 2'b00;
    localparam logic [1:0] CMD_COMMIT  = 2'b01;
    localparam logic [1:0] CMD_READ    = 2'b10;
    localparam logic [1:0] CMD_HALT    = 2'b11;

    state_t              state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   cnt;
    logic [1:0]          cmd;
    logic [ADDR_W-1:0]   port_a_addr;
    logic [ADDR_W-1:0]   port_b_addr;
    logic [CELL_W-1:0]   cell_a;
    logic [CELL_W-1:0]   cell_b;

    logic [CELL_W-1:0]   cells [DEPTH];

    assign cmd = {read_write, write_commit};

    // Port A is shared between the READ low half and the dump stream, since
    // the two are never active in the same cycle; port B is the READ high half.
    always_comb begin
        port_a_addr = addr_data;
        if (state == DUMP) begin
            port_a_addr = cnt;
        end
        port_b_addr = addr_data + ADDR_W'(1);
        cell_a      = cells[port_a_addr];
        cell_b      = cells[port_b_addr];
    end

    // Single write port: only a COMMIT seen while running stores a cell.
    always_ff @(posedge clk) begin
        if (!rst && state == RUN && cmd == CMD_COMMIT) begin
            cells[wr_ptr] <= addr_data[CELL_W-1:0];
        end
    end

    // Command decode, dump sequencing and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            wr_ptr     <= '0;
            cnt        <= '0;
            mem_result <= '0;
            halted     <= 1'b0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    case (cmd)
                        CMD_SETADDR: wr_ptr <= addr_data;
                        CMD_COMMIT:  wr_ptr <= wr_ptr + ADDR_W'(1);
                        CMD_READ:    mem_result <= {cell_b, cell_a};
                        CMD_HALT: begin
                            state  <= DUMP;
                            halted <= 1'b1;
                            cnt    <= '0;
                        end
                        default: ;
                    endcase
                end
                DUMP: begin
                    dump_valid <= 1'b1;
                    dump_addr  <= cnt;
                    dump_data  <= cell_a;
                    cnt        <= cnt + ADDR_W'(1);
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    dump_valid <= 1'b0;
                    dump_done  <= dump_valid;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder with a cycle-level reference model
// and a per-cycle compare process, plus literal spot checks.
module tb_mem_bus_responder;

    logic        clk;
    logic        rst;
    logic        read_write;
    logic        write_commit;
    logic [9:0]  addr_data;
    logic [11:0] mem_result;
    logic        halted;
    logic        dump_valid;
    logic [9:0]  dump_addr;
    logic [5:0]  dump_data;
    logic        dump_done;

    int tests;
    int fails;

    mem_bus_responder dut (
        .clk          (clk),
        .rst          (rst),
        .read_write   (read_write),
        .write_commit (write_commit),
        .addr_data    (addr_data),
        .mem_result   (mem_result),
        .halted       (halted),
        .dump_valid   (dump_valid),
        .dump_addr    (dump_addr),
        .dump_data    (dump_data),
        .dump_done    (dump_done)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: memory contents, write pointer and the expected value
    // of every output, derived from "cycles since the halt was accepted".
    logic [5:0]  model_mem [1024];
    int          wp;
    int          k;
    bit          in_run;
    bit          started;
    bit          chk_dump;
    logic [11:0] m_res;
    logic        m_halt;
    logic        m_valid;
    logic [9:0]  m_addr;
    logic [5:0]  m_data;
    logic        m_done;

    initial begin
        started  = 0;
        in_run   = 1;
        chk_dump = 0;
        wp       = 0;
        k        = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            started  = 1;
            in_run   = 1;
            wp       = 0;
            k        = 0;
            m_res    = '0;
            m_halt   = 1'b0;
            m_valid  = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            m_done   = 1'b0;
            chk_dump = 1;
        end else if (started) begin
            chk_dump = 0;
            if (in_run) begin
                case ({read_write, write_commit})
                    2'b00: wp = int'(addr_data);
                    2'b01: begin
                        model_mem[wp] = addr_data[5:0];
                        wp = (wp + 1) % 1024;
                    end
                    2'b10: m_res = {model_mem[(int'(addr_data) + 1) % 1024],
                                    model_mem[int'(addr_data)]};
                    default: begin
                        in_run = 0;
                        k      = 1;
                        m_halt = 1'b1;
                    end
                endcase
            end else begin
                k++;
                m_valid = (k >= 2 && k <= 1025);
                m_done  = (k == 1026);
                if (m_valid) begin
                    m_addr   = 10'(k - 2);
                    m_data   = model_mem[k - 2];
                    chk_dump = 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Every cycle after the first reset, all outputs must match the model.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("mem_result", 32'(mem_result), 32'(m_res));
            checkOutput("halted", 32'(halted), 32'(m_halt));
            checkOutput("dump_valid", 32'(dump_valid), 32'(m_valid));
            checkOutput("dump_done", 32'(dump_done), 32'(m_done));
            if (chk_dump) begin
                checkOutput("dump_addr", 32'(dump_addr), 32'(m_addr));
                checkOutput("dump_data", 32'(dump_data), 32'(m_data));
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic rw, input logic wc,
                                 input logic [9:0] ad);
        @(posedge clk);
        #2;
        rst          = r;
        read_write   = rw;
        write_commit = wc;
        addr_data    = ad;
    endtask

    int beats;
    int done_pulses;
    int expect_addr;
    bit hit;

    initial begin
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        read_write   = 1'b0;
        write_commit = 1'b0;
        addr_data    = '0;

        // Reset for two clocks, then release.
        applyStimulus(1, 0, 0, 10'd0);
        applyStimulus(1, 0, 0, 10'd0);
        applyStimulus(0, 0, 0, 10'd0);
        @(negedge clk);
        checkOutput("reset mem_result", 32'(mem_result), 32'h0);
        checkOutput("reset halted", 32'(halted), 32'h0);
        checkOutput("reset dump_valid", 32'(dump_valid), 32'h0);
        checkOutput("reset dump_done", 32'(dump_done), 32'h0);

        // Preload every cell with (i*7+3) mod 64 as one long burst from 0.
        for (int i = 0; i < 1024; i++) begin
            applyStimulus(0, 0, 1, 10'((i * 7 + 3) % 64));
        end

        // Write burst at 5 and read back.
        applyStimulus(0, 0, 0, 10'd5);
        applyStimulus(0, 0, 1, 10'h2A);
        applyStimulus(0, 0, 1, 10'h15);
        applyStimulus(0, 1, 0, 10'd5);
        applyStimulus(0, 0, 0, 10'd0);
        @(negedge clk);
        checkOutput("read 5", 32'(mem_result), 32'h56A);
        applyStimulus(0, 1, 0, 10'd6);
        applyStimulus(0, 0, 0, 10'd0);
        @(negedge clk);
        checkOutput("read 6", 32'(mem_result), 32'hD15);
        applyStimulus(0, 0, 0, 10'd0);
        @(negedge clk);
        checkOutput("hold mem_result", 32'(mem_result), 32'hD15);

        // Burst wrapping from the last cell to cell 0.
        applyStimulus(0, 0, 0, 10'd1023);
        applyStimulus(0, 0, 1, 10'h3F);
        applyStimulus(0, 0, 1, 10'h01);
        applyStimulus(0, 1, 0, 10'd1023);
        applyStimulus(0, 0, 0, 10'd0);
        @(negedge clk);
        checkOutput("read wrap", 32'(mem_result), 32'h07F);

        // Back-to-back SETADDR: the last one wins.
        applyStimulus(0, 0, 0, 10'd10);
        applyStimulus(0, 0, 0, 10'd20);
        applyStimulus(0, 0, 1, 10'h11);
        applyStimulus(0, 1, 0, 10'd20);
        applyStimulus(0, 1, 0, 10'd9);
        @(negedge clk);
        checkOutput("read 20", 32'(mem_result), 32'h591);
        applyStimulus(0, 0, 0, 10'd0);
        @(negedge clk);
        checkOutput("read 9", 32'(mem_result), 32'h242);

        // Halt and full dump.
        applyStimulus(0, 1, 1, 10'd0);
        applyStimulus(0, 0, 0, 10'd0);
        @(negedge clk);
        checkOutput("halted after halt", 32'(halted), 32'h1);
        checkOutput("no beat yet", 32'(dump_valid), 32'h0);
        beats       = 0;
        done_pulses = 0;
        expect_addr = 0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (dump_valid) begin
                if (dump_addr !== 10'(expect_addr)) begin
                    checkOutput("dump order", 32'(dump_addr), 32'(expect_addr));
                end
                expect_addr++;
                beats++;
            end
            if (dump_done) done_pulses++;
        end
        checkOutput("dump beats", 32'(beats), 32'd1024);
        checkOutput("dump_done pulses", 32'(done_pulses), 32'd1);
        checkOutput("halted in done", 32'(halted), 32'h1);

        // Commands while done are ignored; reset keeps the cells.
        applyStimulus(0, 0, 1, 10'h3F);
        applyStimulus(0, 1, 0, 10'd0);
        applyStimulus(1, 0, 0, 10'd0);
        applyStimulus(1, 0, 0, 10'd0);
        applyStimulus(0, 1, 0, 10'd20);
        applyStimulus(0, 0, 0, 10'd0);
        @(negedge clk);
        checkOutput("cells kept after done", 32'(mem_result), 32'h591);

        // Reset in the middle of a dump.
        applyStimulus(0, 1, 1, 10'd0);
        applyStimulus(0, 0, 0, 10'd0);
        hit = 0;
        for (int c = 0; c < 400 && !hit; c++) begin
            @(negedge clk);
            if (dump_valid && dump_addr == 10'd300) hit = 1;
        end
        checkOutput("reached beat 300", 32'(hit), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst          = 1'b0;
        read_write   = 1'b1;
        write_commit = 1'b0;
        addr_data    = 10'd5;
        @(negedge clk);
        checkOutput("abort halted", 32'(halted), 32'h0);
        checkOutput("abort dump_valid", 32'(dump_valid), 32'h0);
        checkOutput("abort mem_result", 32'(mem_result), 32'h0);
        applyStimulus(0, 0, 0, 10'd0);
        @(negedge clk);
        checkOutput("read after abort", 32'(mem_result), 32'h56A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
